axi_lite_master_ch: RTL and testbench
=====================================

Name: axi_lite_master_ch

Overview:
Parametrised AXI4-Lite master engine that turns simple request/done command ports into AXI4-Lite transactions. Independent write and read engines run concurrently. Supports per-byte write strobes, configurable widths and PROT, and reports slave responses (BRESP/RRESP) to the user side. Sits between DMA control logic (descriptor/register programming) and the AXI-Lite interconnect.

Parameters:
ADDR_W, 32, address width of AWADDR/ARADDR and request address ports
DATA_W, 32, data width; legal values 32 or 64; STRB_W = DATA_W/8 is derived
PROT, 3'b000, constant driven on AWPROT and ARPROT
TIMEOUT, 256, cycles before timeout flag; used only with AXIL_MST_TIMEOUT_EN

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
wr_req  in  1  write request, qualified by wr_ready
wr_ready  out  1  write engine idle, request accepted when wr_req&&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_strb  in  STRB_W  byte strobes
wr_done  out  1  one-cycle pulse, write response received
wr_resp  out  2  captured BRESP, valid with wr_done
rd_req  in  1  read request, qualified by rd_ready
rd_ready  out  1  read engine idle
rd_addr  in  ADDR_W  read address
rd_done  out  1  one-cycle pulse, read data received
rd_data  out  DATA_W  captured RDATA, held until next rd_done
rd_resp  out  2  captured RRESP, valid with rd_done
AWVALID/AWREADY/AWADDR/AWPROT  out/in/out/out  1/1/ADDR_W/3  write address channel
WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_W/STRB_W  write data channel
BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel
ARVALID/ARREADY/ARADDR/ARPROT  out/in/out/out  1/1/ADDR_W/3  read address channel
RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_W/2  read data channel

Behaviour:
- Reset (async assert, sync release): all VALID/READY outputs 0, AWADDR/ARADDR/WDATA/WSTRB 0, done pulses 0, resp 0, rd_data 0, both FSMs IDLE, wr_ready/rd_ready 1 after release. Reset mid-transaction aborts silently; no done pulse.
- Write FSM: W_IDLE -> W_ADDR (on wr_req&&wr_ready; latch addr/data/strb) -> W_RESP (once AW and W handshakes both done) -> W_IDLE (on BVALID&&BREADY).
- W_ADDR: AWVALID and WVALID rise together the cycle after acceptance; each drops independently the cycle after its own handshake; completion order AW/W arbitrary, simultaneous allowed. Payload stable while VALID high.
- BREADY high only in W_RESP; B handshake -> wr_done=1 next cycle, wr_resp=BRESP latched; wr_ready=1 same cycle as wr_done.
- Read FSM: R_IDLE -> R_ADDR (on rd_req&&rd_ready; ARVALID next cycle) -> R_DATA (after AR handshake; RREADY=1) -> R_IDLE on R handshake; rd_done=1 next cycle with rd_data/rd_resp latched.
- wr_ready/rd_ready = FSM in IDLE (combinational from state). Requests while not ready ignored.
- Write and read fully independent; simultaneous wr_req and rd_req both accepted.
- Minimum latency with always-ready slave: accept cycle N, VALID N+1, RESP phase N+2, done N+3 if B/R returned at N+2.
- Non-OKAY responses are not retried; reported via *_resp only.

Optional Feature:
Macro AXIL_MST_TIMEOUT_EN. Defined: adds outputs wr_timeout, rd_timeout (1 bit each); per-engine counter clears on request acceptance, counts each non-IDLE cycle; on reaching TIMEOUT asserts *_timeout for one cycle, counter then holds; engine keeps waiting (AXI protocol never violated). Undefined: ports and counters absent, no timeout reporting.

Test Plan:
- Write, always-ready slave: wr_addr=0x10, wr_data=0xDEADBEEF, wr_strb=4'hF -> AW/W seen with those values, wr_done 3 cycles after accept, wr_resp=2'b00.
- AWREADY 4 cycles late, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held with AWADDR stable, BREADY only after AW handshake, single wr_done.
- Read with RRESP=2'b10, RDATA=0x12345678 -> rd_done pulse, rd_data=0x12345678, rd_resp=2'b10, rd_ready high again.
- Simultaneous wr_req (addr 0x4) and rd_req (addr 0x8) -> both AW and AR issued same cycle, both done pulses, no cross-corruption.
- ARESETn low while in R_DATA -> RREADY=0 immediately, no rd_done, next read after release completes normally.
- AXIL_MST_TIMEOUT_EN, TIMEOUT=16, BVALID withheld 40 cycles -> wr_timeout pulse 16 cycles after accept, later BVALID still completes with wr_done.

Source files
------------

// File: rtl/axi_lite_master_ch.sv
// AXI4-Lite master: independent write and read engines driven by req/done command ports.
// Optional per-engine timeout reporting is enabled by defining AXIL_MST_TIMEOUT_EN.
module axi_lite_master_ch #(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [2:0] PROT    = 3'b000,
    parameter int         TIMEOUT = 256,
    localparam int        STRB_W  = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    // user write command port
    input  logic              wr_req,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    output logic              wr_done,
    output logic [1:0]        wr_resp,
    // user read command port
    input  logic              rd_req,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_resp,
`ifdef AXIL_MST_TIMEOUT_EN
    output logic              wr_timeout,
    output logic              rd_timeout,
`endif
    // AXI4-Lite write channels
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [2:0]        AWPROT,
    output logic              WVALID,
    input  logic              WREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    input  logic              BVALID,
    output logic              BREADY,
    input  logic [1:0]        BRESP,
    // AXI4-Lite read channels
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [2:0]        ARPROT,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP
);

    localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;

    logic [1:0]        w_state_q, w_state_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              wr_done_q, wr_done_d;
    logic [1:0]        wr_resp_q, wr_resp_d;

    logic [1:0]        r_state_q, r_state_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              rd_done_q, rd_done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        rd_resp_q, rd_resp_d;

    // Write engine: AW and W complete in either order; B is only accepted after both.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
        w_state_d = w_state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_done_d = 1'b0;
        wr_resp_d = wr_resp_q;
        case (w_state_q)
            W_IDLE: if (wr_req) begin
                w_state_d = W_ADDR;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = wr_addr;
                wdata_d   = wr_data;
                wstrb_d   = wr_strb;
            end
            W_ADDR: begin
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) w_state_d = W_RESP;
            end
            W_RESP: if (BVALID) begin
                w_state_d = W_IDLE;
                wr_done_d = 1'b1;
                wr_resp_d = BRESP;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rd_done_d = 1'b0;
        rd_data_d = rd_data_q;
        rd_resp_d = rd_resp_q;
        case (r_state_q)
            R_IDLE: if (rd_req) begin
                r_state_d = R_ADDR;
                arvalid_d = 1'b1;
                araddr_d  = rd_addr;
            end
            R_ADDR: if (ARREADY) begin
                r_state_d = R_DATA;
                arvalid_d = 1'b0;
            end
            R_DATA: if (RVALID) begin
                r_state_d = R_IDLE;
                rd_done_d = 1'b1;
                rd_data_d = RDATA;
                rd_resp_d = RRESP;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same sampled values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_done_q <= 1'b0;
            wr_resp_q <= 2'b00;
            r_state_q <= R_IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rd_done_q <= 1'b0;
            rd_data_q <= '0;
            rd_resp_q <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wr_done_q <= wr_done_d;
            wr_resp_q <= wr_resp_d;
            r_state_q <= r_state_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rd_done_q <= rd_done_d;
            rd_data_q <= rd_data_d;
            rd_resp_q <= rd_resp_d;
        end
    end

    assign wr_ready = (w_state_q == W_IDLE);
    assign rd_ready = (r_state_q == R_IDLE);
    assign wr_done  = wr_done_q;
    assign wr_resp  = wr_resp_q;
    assign rd_done  = rd_done_q;
    assign rd_data  = rd_data_q;
    assign rd_resp  = rd_resp_q;

    assign AWVALID = awvalid_q;
    assign AWADDR  = awaddr_q;
    assign AWPROT  = PROT;
    assign WVALID  = wvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign BREADY  = (w_state_q == W_RESP);
    assign ARVALID = arvalid_q;
    assign ARADDR  = araddr_q;
    assign ARPROT  = PROT;
    assign RREADY  = (r_state_q == R_DATA);

`ifdef AXIL_MST_TIMEOUT_EN
    // Counters saturate at TIMEOUT so the flag fires once per transaction; the engine keeps waiting.
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_req && wr_ready)
            wr_cnt_d = '0;
        else if (!wr_ready && wr_cnt_q != TO_W'(TIMEOUT))
            wr_cnt_d = wr_cnt_q + TO_W'(1);
        if (rd_req && rd_ready)
            rd_cnt_d = '0;
        else if (!rd_ready && rd_cnt_q != TO_W'(TIMEOUT))
            rd_cnt_d = rd_cnt_q + TO_W'(1);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // The TIMEOUT-th busy cycle is the one whose count still reads TIMEOUT-1.
    assign wr_timeout = !wr_ready && (wr_cnt_q == TO_W'(TIMEOUT - 1));
    assign rd_timeout = !rd_ready && (rd_cnt_q == TO_W'(TIMEOUT - 1));
`endif

endmodule

// File: tb/tb_axi_lite_master_ch.sv
// Bench for axi_lite_master_ch: table vectors, randomized transactions against a latency/data
// model, a configurable-delay slave with protocol monitors, and a reset-abort sequence.
module tb_axi_lite_master_ch;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    logic              wr_req, wr_ready, wr_done;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [1:0]        wr_resp;
    logic              rd_req, rd_ready, rd_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_resp;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [2:0]        AWPROT, ARPROT;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [STRB_W-1:0] WSTRB;
    logic [1:0]        BRESP, RRESP;
`ifdef AXIL_MST_TIMEOUT_EN
    logic              wr_timeout, rd_timeout;
`endif

    axi_lite_master_ch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROT(3'b010), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_strb(wr_strb), .wr_done(wr_done), .wr_resp(wr_resp),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_done(rd_done),
        .rd_data(rd_data), .rd_resp(rd_resp),
`ifdef AXIL_MST_TIMEOUT_EN
        .wr_timeout(wr_timeout), .rd_timeout(rd_timeout),
`endif
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: done arrives 3 cycles after accept, stretched by the slowest address/data
    // handshake and by the slave's response delay.
    function automatic int exp_wr_lat(input int awd, input int wd, input int bd);
        return 3 + ((awd > wd) ? awd : wd) + bd;
    endfunction

    function automatic int exp_rd_lat(input int ard, input int rdd);
        return 3 + ard + rdd;
    endfunction

    // ---------------- slave model ----------------
    int aw_dly_cfg, w_dly_cfg, b_dly_cfg, ar_dly_cfg, r_dly_cfg;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] rdata_cfg;

    bit aw_act, w_act, ar_act, b_wait, r_wait;
    bit aw_just, w_just, ar_just, b_fire, r_fire;
    int aw_left, w_left, ar_left, b_left, r_left;
    int aw_hs, w_hs, b_cnt, ar_hs, r_cnt;
    int aw_first, w_first, ar_first;
    logic [31:0] aw_hold, ar_hold;
    logic [35:0] w_hold;
    logic [31:0] aw_q[$], ar_q[$];
    logic [35:0] w_q[$];

    task slave_reset();
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_act = 0; w_act = 0; ar_act = 0; b_wait = 0; r_wait = 0;
        aw_just = 0; w_just = 0; ar_just = 0; b_fire = 0; r_fire = 0;
        aw_hs = 0; w_hs = 0; b_cnt = 0; ar_hs = 0; r_cnt = 0;
        aw_q.delete(); w_q.delete(); ar_q.delete();
    endtask

    // Decisions are made at the falling edge; a VALID&&READY seen here completes at the next rising edge.
    initial begin
        slave_reset();
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                slave_reset();
            end else begin
                if (b_fire) begin BVALID = 0; b_fire = 0; end
                if (BREADY) check("bready_after_aw_w", (aw_hs > b_cnt) && (w_hs > b_cnt), 1);
                if (!BVALID && aw_hs > b_cnt && w_hs > b_cnt) begin
                    if (!b_wait) begin b_wait = 1; b_left = b_dly_cfg; end
                    if (b_left == 0) begin BVALID = 1; BRESP = bresp_cfg; b_wait = 0; end
                    else b_left--;
                end
                if (BVALID && BREADY) begin b_fire = 1; b_cnt++; end

                if (r_fire) begin RVALID = 0; r_fire = 0; end
                if (RREADY) check("rready_after_ar", ar_hs > r_cnt, 1);
                if (!RVALID && ar_hs > r_cnt) begin
                    if (!r_wait) begin r_wait = 1; r_left = r_dly_cfg; end
                    if (r_left == 0) begin RVALID = 1; RDATA = rdata_cfg; RRESP = rresp_cfg; r_wait = 0; end
                    else r_left--;
                end
                if (RVALID && RREADY) begin r_fire = 1; r_cnt++; end

                if (aw_just) begin check("awvalid_drop", AWVALID, 0); aw_just = 0; end
                AWREADY = 0;
                if (AWVALID) begin
                    if (!aw_act) begin aw_act = 1; aw_left = aw_dly_cfg; aw_hold = AWADDR; aw_first = cyc; end
                    else check("awaddr_stable", AWADDR, aw_hold);
                    if (aw_left == 0) begin
                        AWREADY = 1; aw_act = 0; aw_just = 1; aw_hs++; aw_q.push_back(AWADDR);
                    end else aw_left--;
                end

                if (w_just) begin check("wvalid_drop", WVALID, 0); w_just = 0; end
                WREADY = 0;
                if (WVALID) begin
                    if (!w_act) begin w_act = 1; w_left = w_dly_cfg; w_hold = {WSTRB, WDATA}; w_first = cyc; end
                    else check("wdata_stable", {WSTRB, WDATA}, w_hold);
                    if (w_left == 0) begin
                        WREADY = 1; w_act = 0; w_just = 1; w_hs++; w_q.push_back({WSTRB, WDATA});
                    end else w_left--;
                end

                if (ar_just) begin check("arvalid_drop", ARVALID, 0); ar_just = 0; end
                ARREADY = 0;
                if (ARVALID) begin
                    if (!ar_act) begin ar_act = 1; ar_left = ar_dly_cfg; ar_hold = ARADDR; ar_first = cyc; end
                    else check("araddr_stable", ARADDR, ar_hold);
                    if (ar_left == 0) begin
                        ARREADY = 1; ar_act = 0; ar_just = 1; ar_hs++; ar_q.push_back(ARADDR);
                    end else ar_left--;
                end
            end
        end
    end

    int rd_done_cnt = 0;
    always @(negedge ACLK) if (rd_done) rd_done_cnt <= rd_done_cnt + 1;

    // ---------------- command-side drivers ----------------
    int wr_acc_cyc;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd, input logic [1:0] br,
                            input int lat);
        int t;
        int acc;
        aw_dly_cfg = awd; w_dly_cfg = wd; b_dly_cfg = bd; bresp_cfg = br;
        @(negedge ACLK);
        t = 0;
        while (!wr_ready && t < 20) begin @(negedge ACLK); t++; end
        if (!wr_ready) begin check("wr_ready_wait", 0, 1); return; end
        wr_addr = a; wr_data = d; wr_strb = s; wr_req = 1; acc = cyc; wr_acc_cyc = acc;
        @(negedge ACLK);
        wr_req = 0;
        check("wr_busy", wr_ready, 0);
        t = 0;
        while (!wr_done && t < 200) begin @(negedge ACLK); t++; end
        if (!wr_done) begin check("wr_done_timeout", 0, 1); return; end
        check("wr_latency", cyc - acc, lat);
        check("wr_resp", wr_resp, br);
        check("wr_ready_at_done", wr_ready, 1);
        check("aw_issue_cycle", aw_first, acc + 1);
        check("w_issue_cycle", w_first, acc + 1);
        if (aw_q.size() == 0) check("aw_seen", 0, 1);
        else check("awaddr", aw_q.pop_front(), a);
        if (w_q.size() == 0) check("w_seen", 0, 1);
        else check("wstrb_wdata", w_q.pop_front(), {s, d});
        @(negedge ACLK);
        check("wr_done_pulse", wr_done, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int ard,
                           input int rdd, input logic [1:0] rr, input int lat);
        int t;
        int acc;
        ar_dly_cfg = ard; r_dly_cfg = rdd; rdata_cfg = d; rresp_cfg = rr;
        @(negedge ACLK);
        t = 0;
        while (!rd_ready && t < 20) begin @(negedge ACLK); t++; end
        if (!rd_ready) begin check("rd_ready_wait", 0, 1); return; end
        rd_addr = a; rd_req = 1; acc = cyc;
        @(negedge ACLK);
        rd_req = 0;
        check("rd_busy", rd_ready, 0);
        t = 0;
        while (!rd_done && t < 200) begin @(negedge ACLK); t++; end
        if (!rd_done) begin check("rd_done_timeout", 0, 1); return; end
        check("rd_latency", cyc - acc, lat);
        check("rd_data", rd_data, d);
        check("rd_resp", rd_resp, rr);
        check("rd_ready_at_done", rd_ready, 1);
        check("ar_issue_cycle", ar_first, acc + 1);
        if (ar_q.size() == 0) check("ar_seen", 0, 1);
        else check("araddr", ar_q.pop_front(), a);
        @(negedge ACLK);
        check("rd_done_pulse", rd_done, 0);
        check("rd_data_held", rd_data, d);
    endtask

    typedef struct {
        logic [31:0] waddr, wdata;
        logic [3:0]  wstrb;
        int          awd, wd, bd;
        logic [1:0]  bresp;
        int          wlat;
        logic [31:0] raddr, rdata;
        int          ard, rdd;
        logic [1:0]  rresp;
        int          rlat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        ARESETn = 0;
        wr_req = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        rd_req = 0; rd_addr = 0;
        aw_dly_cfg = 0; w_dly_cfg = 0; b_dly_cfg = 0; ar_dly_cfg = 0; r_dly_cfg = 0;
        bresp_cfg = 0; rresp_cfg = 0; rdata_cfg = 0;

        //              waddr         wdata         strb  aw w  b  bresp  wlat raddr         rdata         ar r  rresp rlat
        vecs[0] = '{32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 3, 32'h20,       32'hCAFEF00D, 0, 0, 2'b00, 3};
        vecs[1] = '{32'h14,       32'h01020304, 4'h3, 4, 0, 0, 2'b00, 7, 32'h24,       32'h12345678, 0, 0, 2'b10, 3};
        vecs[2] = '{32'h4,        32'hA5A55A5A, 4'h5, 0, 2, 1, 2'b01, 6, 32'h8,        32'h0BADF00D, 2, 1, 2'b11, 6};
        vecs[3] = '{32'h1C,       32'h00000000, 4'h0, 1, 3, 2, 2'b11, 8, 32'hFFFFFFFC, 32'hFFFFFFFF, 0, 5, 2'b00, 8};
        vecs[4] = '{32'h80000000, 32'h7FFFFFFF, 4'h8, 2, 2, 0, 2'b10, 5, 32'h0,        32'h00000000, 3, 0, 2'b01, 6};

        repeat (3) @(negedge ACLK);
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid", WVALID, 0);
        check("rst_bready", BREADY, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_rready", RREADY, 0);
        check("rst_addrs", {AWADDR, ARADDR}, 0);
        check("rst_wpayload", {WSTRB, WDATA}, 0);
        check("rst_dones", {wr_done, rd_done}, 0);
        check("rst_resps", {wr_resp, rd_resp}, 0);
        check("rst_rd_data", rd_data, 0);
        check("prot", {AWPROT, ARPROT}, 6'b010_010);
        ARESETn = 1;
        @(negedge ACLK);
        check("idle_wr_ready", wr_ready, 1);
        check("idle_rd_ready", rd_ready, 1);

        for (int i = 0; i < 5; i++) begin
            fork
                do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].awd, vecs[i].wd,
                         vecs[i].bd, vecs[i].bresp, vecs[i].wlat);
                do_read(vecs[i].raddr, vecs[i].rdata, vecs[i].ard, vecs[i].rdd,
                        vecs[i].rresp, vecs[i].rlat);
            join
        end

        for (int i = 0; i < 24; i++) begin
            int mode, awd, wd, bd, ard, rdd;
            logic [31:0] wa, wdat, ra, rdat;
            logic [3:0]  ws;
            logic [1:0]  br, rr;
            mode = $urandom_range(0, 2);
            awd = $urandom_range(0, 4); wd = $urandom_range(0, 4); bd = $urandom_range(0, 3);
            ard = $urandom_range(0, 4); rdd = $urandom_range(0, 4);
            wa = $urandom & 32'hFFFF_FFFC; wdat = $urandom; ws = 4'($urandom);
            ra = $urandom & 32'hFFFF_FFFC; rdat = $urandom;
            br = 2'($urandom); rr = 2'($urandom);
            fork
                if (mode != 2) do_write(wa, wdat, ws, awd, wd, bd, br, exp_wr_lat(awd, wd, bd));
                if (mode != 1) do_read(ra, rdat, ard, rdd, rr, exp_rd_lat(ard, rdd));
            join
        end

        // Reset while the read engine waits in its data phase: abort without a done pulse.
        begin
            int t;
            int done_before;
            ar_dly_cfg = 0; r_dly_cfg = 10; rdata_cfg = 32'h5555AAAA; rresp_cfg = 2'b00;
            @(negedge ACLK);
            rd_addr = 32'h40; rd_req = 1;
            @(negedge ACLK);
            rd_req = 0;
            t = 0;
            while (!RREADY && t < 10) begin @(negedge ACLK); t++; end
            check("rready_before_reset", RREADY, 1);
            #1 done_before = rd_done_cnt;
            @(posedge ACLK);
            #2 ARESETn = 0;
            #1 check("rready_in_reset", RREADY, 0);
            repeat (2) @(negedge ACLK);
            ARESETn = 1;
            repeat (14) @(negedge ACLK);
            #1 check("no_rd_done_after_abort", rd_done_cnt, done_before);
            check("rd_ready_after_abort", rd_ready, 1);
            do_read(32'h44, 32'h13579BDF, 0, 0, 2'b00, 3);
        end

`ifdef AXIL_MST_TIMEOUT_EN
        begin
            int to_cyc;
            int to_pulses;
            to_cyc = -1;
            to_pulses = 0;
            fork
                do_write(32'h100, 32'h0F0F0F0F, 4'hF, 0, 0, 40, 2'b00, exp_wr_lat(0, 0, 40));
                for (int k = 0; k < 60; k++) begin
                    @(negedge ACLK);
                    if (wr_timeout) begin to_pulses++; if (to_cyc < 0) to_cyc = cyc; end
                end
            join
            check("wr_timeout_cycle", to_cyc - wr_acc_cyc, 16);
            check("wr_timeout_pulses", to_pulses, 1);
        end
`endif

        repeat (3) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
